cook_timer_fsm: RTL

COOK_TIMER_FSM -- requirements
Module: cook_timer_fsm

---
 rtl/egg_timer_pkg.sv | 27 ++
 rtl/edge_detect.sv | 28 ++
 rtl/cook_timer_fsm.sv | 135 +++++++++++++
 3 files changed

// File: rtl/egg_timer_pkg.sv
// Shared state encoding, time limits and button indices for the cook timer.
// Time values are 6-bit unsigned and never leave the range 0..59.
package egg_timer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SET   = 3'd1,
      ST_RUN   = 3'd2,
      ST_PAUSE = 3'd3,
      ST_DONE  = 3'd4
   } state_e;

   localparam logic [5:0] MAX_MIN = 6'd59;
   localparam logic [5:0] MAX_SEC = 6'd59;

   localparam int NUM_BTN  = 4;
   localparam int BTN_COOK = 0;
   localparam int BTN_START = 1;
   localparam int BTN_MIN  = 2;
   localparam int BTN_SEC  = 3;

   // Wrap at max before adding so the sum never exceeds the limit.
   function automatic logic [5:0] inc_wrap(input logic [5:0] v, input logic [5:0] max);
      return (v >= max) ? 6'd0 : v + 6'd1;
   endfunction

endpackage

// File: rtl/edge_detect.sv
// Registered rising-edge detector: one pulse, one cycle after the edge.
// armed_q stays low until the input is seen low, so a press held through reset is swallowed.
module edge_detect (
   input  logic clock,
   input  logic reset,
   input  logic in,
   output logic pulse
);

   logic prev_q;
   logic armed_q;
   logic pulse_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         prev_q  <= 1'b0;
         armed_q <= 1'b0;
         pulse_q <= 1'b0;
      end else begin
         prev_q  <= in;
         armed_q <= armed_q | ~in;
         pulse_q <= in & ~prev_q & armed_q;
      end
   end

   assign pulse = pulse_q;

endmodule

// File: rtl/cook_timer_fsm.sv
// Kitchen countdown timer: set mm:ss with buttons, run/pause on start,
// blink the alarm LED in DONE for ALARM_SECS ticks, then fall back to IDLE.
module cook_timer_fsm
   import egg_timer_pkg::*;
#(
   parameter int ALARM_SECS = 10
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       tick_1hz,
   input  logic       cook_time,
   input  logic       start,
   input  logic       minutes,
   input  logic       seconds,
   output logic [5:0] q_minutes,
   output logic [5:0] q_seconds,
   output logic [2:0] state,
   output logic       done,
   output logic [1:0] LED
);

   localparam int ALARM_W = $clog2(ALARM_SECS + 1);
   localparam logic [ALARM_W-1:0] ALARM_LAST = ALARM_W'(ALARM_SECS - 1);

   logic [NUM_BTN-1:0] btn;
   logic [NUM_BTN-1:0] ev;

   state_e             state_q, state_d;
   logic [5:0]         min_q, min_d;
   logic [5:0]         sec_q, sec_d;
   logic [ALARM_W-1:0] alarm_q, alarm_d;
   logic               blink_q, blink_d;

   assign btn[BTN_COOK]  = cook_time;
   assign btn[BTN_START] = start;
   assign btn[BTN_MIN]   = minutes;
   assign btn[BTN_SEC]   = seconds;

   for (genvar g = 0; g < NUM_BTN; g++) begin : g_edge
      edge_detect u_edge (
         .clock (clock),
         .reset (reset),
         .in    (btn[g]),
         .pulse (ev[g])
      );
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ST_IDLE;
         min_q   <= 6'd0;
         sec_q   <= 6'd0;
         alarm_q <= '0;
         blink_q <= 1'b0;
      end else begin
         state_q <= state_d;
         min_q   <= min_d;
         sec_q   <= sec_d;
         alarm_q <= alarm_d;
         blink_q <= blink_d;
      end
   end

   // One event per cycle, highest priority wins: cook > start > min/sec > tick.
   always_comb begin
      state_d = state_q;
      min_d   = min_q;
      sec_d   = sec_q;
      alarm_d = alarm_q;
      blink_d = blink_q;
      if (ev[BTN_COOK]) begin
         state_d = ST_SET;
         alarm_d = '0;
         blink_d = 1'b0;
         if (state_q == ST_IDLE || state_q == ST_DONE) begin
            min_d = 6'd0;
            sec_d = 6'd0;
         end
      end else if (ev[BTN_START]) begin
         case (state_q)
            ST_SET:   if (min_q != 6'd0 || sec_q != 6'd0) state_d = ST_RUN;
            ST_RUN:   state_d = ST_PAUSE;
            ST_PAUSE: state_d = ST_RUN;
            ST_DONE: begin
               state_d = ST_IDLE;
               alarm_d = '0;
               blink_d = 1'b0;
            end
            default: ;
         endcase
      end else if (ev[BTN_MIN] || ev[BTN_SEC]) begin
         if (state_q == ST_SET) begin
            if (ev[BTN_MIN]) min_d = inc_wrap(min_q, MAX_MIN);
            if (ev[BTN_SEC]) sec_d = inc_wrap(sec_q, MAX_SEC);
         end
      end else if (tick_1hz) begin
         case (state_q)
            ST_RUN: begin
               if (sec_q != 6'd0) begin
                  sec_d = sec_q - 6'd1;
               end else begin
                  min_d = min_q - 6'd1;
                  sec_d = MAX_SEC;
               end
               if (min_q == 6'd0 && sec_q == 6'd1) begin
                  state_d = ST_DONE;
                  alarm_d = '0;
                  blink_d = 1'b1;
               end
            end
            ST_DONE: begin
               if (alarm_q == ALARM_LAST) begin
                  state_d = ST_IDLE;
                  alarm_d = '0;
                  blink_d = 1'b0;
               end else begin
                  alarm_d = alarm_q + ALARM_W'(1);
                  blink_d = ~blink_q;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state     = state_q;
      q_minutes = min_q;
      q_seconds = sec_q;
      done      = (state_q == ST_DONE);
      LED[0]    = (state_q == ST_RUN);
      LED[1]    = blink_q & (state_q == ST_DONE);
   end

endmodule
